// File: rtl/frame_catch_pack.sv
// frame_catch_pack
// Hunts SOF,SOF / KIND / LEN / payload / EOF,EOF frames on a W_IN-bit word
// stream, skips K-char idles, checks LEN and the EOF pair, and packs every
// frame word into PACK-lane beats presented on a valid/ready output register.
module frame_catch_pack #(
  parameter int              W_IN     = 16,
  parameter int              PACK     = 4,
  parameter logic [W_IN-1:0] SOF_WORD = 16'hA0AA,
  parameter logic [W_IN-1:0] EOF_WORD = 16'hAAAA,
  parameter logic [W_IN-1:0] PAD_WORD = 16'h0000,
  parameter int              MAX_LEN  = 4096,
  parameter int              CNT_W    = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [W_IN-1:0]      Data_in,
  input  logic                 Char_in,
  output logic [W_IN*PACK-1:0] Data_Out,
  output logic                 Valid_Out,
  input  logic                 Ready_In,
  output logic                 Last_Out,
  output logic                 Err_Out,
  output logic                 Abort_Out,
  output logic [CNT_W-1:0]     Frm_Cnt,
  output logic [CNT_W-1:0]     Err_Cnt,
  output logic [CNT_W-1:0]     Drop_Cnt
);

  localparam int               IDX_W     = $clog2(PACK);
  localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(PACK - 1);
  localparam logic [31:0]      MAX_LEN_W = 32'(MAX_LEN);

  typedef enum logic [2:0] {
    S_HUNT,
    S_SOF2,
    S_KIND,
    S_LEN,
    S_PAY,
    S_EOF1,
    S_EOF2
  } state_t;

  // Frame parser state
  state_t            state_q, state_d;
  logic [IDX_W-1:0]  lane_idx_q, lane_idx_d;
  logic [W_IN-1:0]   remain_q, remain_d;
  logic              eof_err_q, eof_err_d;

  // Output beat register and status
  logic                 valid_q, valid_d;
  logic [W_IN*PACK-1:0] data_q, data_d;
  logic                 last_q, last_d;
  logic                 err_q, err_d;
  logic                 abort_q, abort_d;
  logic [CNT_W-1:0]     frm_cnt_q, frm_cnt_d;
  logic [CNT_W-1:0]     err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0]     drop_cnt_q, drop_cnt_d;

  // Per-cycle decode results
  logic                 accept;        // current word belongs to the frame
  logic                 beat_done;     // current word closes a beat
  logic                 beat_last;     // closing word is EOF2
  logic                 beat_err;      // EOF pair check failed
  logic                 abort_req;     // LEN out of range
  logic                 drop_partial;  // second SOF missing: forget first SOF
  logic                 overflow;      // beat completes with no room to hold it
  logic                 abort_now;
  logic                 load_beat;
  logic                 clear_lanes;
  logic                 len_too_big;
  logic [W_IN*PACK-1:0] beat_data;

  assign len_too_big = 32'(Data_in) > MAX_LEN_W;

  // Frame parsing, beat completion, abort decisions and next output state
  always_comb begin
    state_d      = state_q;
    lane_idx_d   = lane_idx_q;
    remain_d     = remain_q;
    eof_err_d    = eof_err_q;
    accept       = 1'b0;
    beat_done    = 1'b0;
    beat_last    = 1'b0;
    beat_err     = 1'b0;
    abort_req    = 1'b0;
    drop_partial = 1'b0;

    case (state_q)
      S_HUNT: begin
        // SOF detection deliberately ignores Char_in.
        if (Data_in == SOF_WORD) begin
          accept  = 1'b1;
          state_d = S_SOF2;
        end
      end
      S_SOF2: begin
        if (!Char_in) begin
          if (Data_in == SOF_WORD) begin
            accept  = 1'b1;
            state_d = S_KIND;
          end else begin
            drop_partial = 1'b1;
            state_d      = S_HUNT;
          end
        end
      end
      S_KIND: begin
        if (!Char_in) begin
          accept  = 1'b1;
          state_d = S_LEN;
        end
      end
      S_LEN: begin
        if (!Char_in) begin
          accept   = 1'b1;
          remain_d = Data_in;
          if (len_too_big) begin
            abort_req = 1'b1;
          end else if (Data_in == '0) begin
            state_d = S_EOF1;
          end else begin
            state_d = S_PAY;
          end
        end
      end
      S_PAY: begin
        if (!Char_in) begin
          accept   = 1'b1;
          remain_d = remain_q - W_IN'(1);
          if (remain_q == W_IN'(1)) begin
            state_d = S_EOF1;
          end
        end
      end
      S_EOF1: begin
        if (!Char_in) begin
          accept    = 1'b1;
          eof_err_d = (Data_in != EOF_WORD);
          state_d   = S_EOF2;
        end
      end
      S_EOF2: begin
        if (!Char_in) begin
          accept    = 1'b1;
          beat_last = 1'b1;
          beat_err  = eof_err_q | (Data_in != EOF_WORD);
          state_d   = S_HUNT;
        end
      end
      default: begin
        state_d = S_HUNT;
      end
    endcase

    if (accept) begin
      beat_done  = beat_last | (lane_idx_q == LAST_LANE);
      lane_idx_d = beat_done ? '0 : lane_idx_q + IDX_W'(1);
    end
    if (drop_partial) begin
      lane_idx_d = '0;
    end

    // The held beat can only be replaced if it is empty or leaving now.
    overflow  = beat_done & valid_q & ~Ready_In;
    abort_now = abort_req | overflow;
    if (abort_now) begin
      state_d    = S_HUNT;
      lane_idx_d = '0;
    end

    load_beat   = beat_done & ~abort_now;
    clear_lanes = beat_done | abort_now | drop_partial;

    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    err_d   = err_q;
    if (valid_q && Ready_In) begin
      valid_d = 1'b0;
    end
    if (load_beat) begin
      valid_d = 1'b1;
      data_d  = beat_data;
      last_d  = beat_last;
      err_d   = beat_err;
    end

    abort_d    = abort_now;
    frm_cnt_d  = frm_cnt_q + CNT_W'(load_beat & beat_last);
    err_cnt_d  = err_cnt_q + CNT_W'(load_beat & beat_last & beat_err);
    drop_cnt_d = drop_cnt_q + CNT_W'(abort_now);
  end

  // Lane storage: earlier lanes come from the partial buffer, the current
  // word drops straight into its lane, and lanes after it are padding
  // (only reachable on the EOF2 beat).
  genvar gi;
  generate
    for (gi = 0; gi < PACK; gi++) begin : g_lane
      logic [W_IN-1:0] lane_q, lane_d;

      assign beat_data[gi*W_IN +: W_IN] =
        (IDX_W'(gi) <  lane_idx_q) ? lane_q  :
        (IDX_W'(gi) == lane_idx_q) ? Data_in : PAD_WORD;

      // Capture the accepted word into its lane; empty on beat close or abort
      always_comb begin
        lane_d = lane_q;
        if (clear_lanes) begin
          lane_d = '0;
        end else if (accept && (lane_idx_q == IDX_W'(gi))) begin
          lane_d = Data_in;
        end
      end

      // Lane register
      always_ff @(posedge CLK) begin
        if (RST) begin
          lane_q <= '0;
        end else begin
          lane_q <= lane_d;
        end
      end
    end
  endgenerate

  // Parser state, output beat register and status counters
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_HUNT;
      lane_idx_q <= '0;
      remain_q   <= '0;
      eof_err_q  <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      last_q     <= 1'b0;
      err_q      <= 1'b0;
      abort_q    <= 1'b0;
      frm_cnt_q  <= '0;
      err_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      lane_idx_q <= lane_idx_d;
      remain_q   <= remain_d;
      eof_err_q  <= eof_err_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      last_q     <= last_d;
      err_q      <= err_d;
      abort_q    <= abort_d;
      frm_cnt_q  <= frm_cnt_d;
      err_cnt_q  <= err_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign Data_Out  = data_q;
  assign Valid_Out = valid_q;
  assign Last_Out  = last_q;
  assign Err_Out   = err_q;
  assign Abort_Out = abort_q;
  assign Frm_Cnt   = frm_cnt_q;
  assign Err_Cnt   = err_cnt_q;
  assign Drop_Cnt  = drop_cnt_q;

endmodule

// File: tb/tb_frame_catch_pack.sv
// Bench for frame_catch_pack: a table-driven basic frame, directed corner
// sequences, and randomized frames against a queue-based frame model.
`timescale 1ns/1ps
module tb_frame_catch_pack;

  localparam int          PACK    = 4;
  localparam int          MAX_LEN = 4096;
  localparam logic [15:0] SOF     = 16'hA0AA;
  localparam logic [15:0] EOF     = 16'hAAAA;
  localparam logic [15:0] PAD     = 16'h0000;
  localparam logic [15:0] IDLE    = 16'hBC50;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] data_in = '0;
  logic        char_in = 1'b0;
  logic        ready_in = 1'b0;
  logic [63:0] data_out;
  logic        valid_out, last_out, err_out, abort_out;
  logic [15:0] frm_cnt, err_cnt, drop_cnt;

  always #5 clk = ~clk;

  frame_catch_pack dut (
    .CLK       (clk),
    .RST       (rst),
    .Data_in   (data_in),
    .Char_in   (char_in),
    .Data_Out  (data_out),
    .Valid_Out (valid_out),
    .Ready_In  (ready_in),
    .Last_Out  (last_out),
    .Err_Out   (err_out),
    .Abort_Out (abort_out),
    .Frm_Cnt   (frm_cnt),
    .Err_Cnt   (err_cnt),
    .Drop_Cnt  (drop_cnt)
  );

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model: frame position, words collected so far, one-beat slot.
  int          m_pos;   // 0 hunting, 1 after SOF1, 2 want KIND, 3 want LEN, 4 payload, 5 want EOF1, 6 want EOF2
  int          m_left;
  bit          m_e1;
  logic [15:0] m_words[$];
  bit          m_valid, m_last, m_err, m_abort;
  logic [63:0] m_data;
  logic [15:0] m_frm, m_errc, m_drop;

  logic [65:0] got[$];     // {last, err, data} of beats seen with ready high
  logic [15:0] stim[$];

  function automatic void model_reset();
    m_pos = 0; m_left = 0; m_e1 = 0; m_words.delete();
    m_valid = 0; m_last = 0; m_err = 0; m_abort = 0; m_data = '0;
    m_frm = '0; m_errc = '0; m_drop = '0;
  endfunction

  function automatic void model_step(input logic [15:0] d, input bit k, input bit r);
    bit acc, done, last, eb, ab;
    logic [63:0] beat;
    acc = 0; done = 0; last = 0; eb = 0; ab = 0; beat = '0;
    if (m_pos == 0) begin
      if (d == SOF) begin acc = 1; m_pos = 1; end
    end else if (!k) begin
      acc = 1;
      case (m_pos)
        1: if (d == SOF) m_pos = 2;
           else begin acc = 0; m_pos = 0; m_words.delete(); end
        2: m_pos = 3;
        3: begin
             m_left = int'(d);
             if (m_left > MAX_LEN) ab = 1;
             else m_pos = (m_left == 0) ? 5 : 4;
           end
        4: begin m_left--; if (m_left == 0) m_pos = 5; end
        5: begin m_e1 = (d != EOF); m_pos = 6; end
        default: begin last = 1; eb = m_e1 || (d != EOF); m_pos = 0; end
      endcase
    end
    if (acc) m_words.push_back(d);
    done = acc && ((m_words.size() == PACK) || last);
    if (done && m_valid && !r) ab = 1;
    for (int i = 0; i < PACK; i++)
      beat[i*16 +: 16] = (i < m_words.size()) ? m_words[i] : PAD;
    if (done || ab) m_words.delete();
    if (ab) m_pos = 0;
    if (m_valid && r) m_valid = 0;
    if (done && !ab) begin
      m_valid = 1; m_data = beat; m_last = last; m_err = eb;
      if (last) begin m_frm++; if (eb) m_errc++; end
    end
    m_abort = ab;
    if (ab) m_drop++;
  endfunction

  task automatic check_all(input string tag);
    n_vec++;
    if (valid_out !== m_valid || data_out !== m_data || last_out !== m_last ||
        err_out !== m_err || abort_out !== m_abort || frm_cnt !== m_frm ||
        err_cnt !== m_errc || drop_cnt !== m_drop) begin
      n_miss++;
      $display("FAIL %s @%0t: got v=%b d=%h l=%b e=%b a=%b f=%0d ec=%0d dc=%0d, want v=%b d=%h l=%b e=%b a=%b f=%0d ec=%0d dc=%0d",
               tag, $time, valid_out, data_out, last_out, err_out, abort_out, frm_cnt, err_cnt, drop_cnt,
               m_valid, m_data, m_last, m_err, m_abort, m_frm, m_errc, m_drop);
    end
  endtask

  task automatic chk(input string tag, input logic [65:0] act, input logic [65:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  // One clock: drive inputs, advance the model, compare after the edge.
  task automatic cyc(input logic [15:0] d, input bit k, input bit r, input string tag);
    data_in = d; char_in = k; ready_in = r;
    model_step(d, k, r);
    @(posedge clk); #1;
    check_all(tag);
    if (valid_out && r) begin
      got.push_back({last_out, err_out, data_out});
      $display("%s beat d=%h last=%b err=%b", tag, data_out, last_out, err_out);
    end
  endtask

  task automatic do_reset();
    rst = 1; data_in = '0; char_in = 0; ready_in = 0;
    @(posedge clk); #1;
    model_reset();
    check_all("reset");
    rst = 0;
    got.delete();
  endtask

  // Send stim[] with a number of K-char idles between consecutive words.
  task automatic play(input int idles, input bit r, input string tag);
    foreach (stim[i]) begin
      cyc(stim[i], 1'b0, r, tag);
      if (i != stim.size() - 1)
        for (int j = 0; j < idles; j++) cyc(IDLE, 1'b1, r, tag);
    end
  endtask

  typedef struct {
    logic [15:0] d;
    bit          k;
    bit          rdy;
    bit          e_valid;
    logic [63:0] e_data;
    bit          e_last;
    bit          e_err;
    logic [15:0] e_frm;
  } vec_t;

  vec_t tbl[9];

  localparam logic [63:0] T1_B0 = 64'h0002_0001_A0AA_A0AA;
  localparam logic [63:0] T1_B1 = 64'hAAAA_AAAA_2222_1111;

  logic [63:0] held;
  int          len;
  bit          rmode;
  bit          rr;

  initial begin
    tbl[0] = '{16'hA0AA, 1'b0, 1'b1, 1'b0, 64'h0,  1'b0, 1'b0, 16'd0};
    tbl[1] = '{16'hA0AA, 1'b0, 1'b1, 1'b0, 64'h0,  1'b0, 1'b0, 16'd0};
    tbl[2] = '{16'h0001, 1'b0, 1'b1, 1'b0, 64'h0,  1'b0, 1'b0, 16'd0};
    tbl[3] = '{16'h0002, 1'b0, 1'b1, 1'b1, T1_B0,  1'b0, 1'b0, 16'd0};
    tbl[4] = '{16'h1111, 1'b0, 1'b1, 1'b0, 64'h0,  1'b0, 1'b0, 16'd0};
    tbl[5] = '{16'h2222, 1'b0, 1'b1, 1'b0, 64'h0,  1'b0, 1'b0, 16'd0};
    tbl[6] = '{16'hAAAA, 1'b0, 1'b1, 1'b0, 64'h0,  1'b0, 1'b0, 16'd0};
    tbl[7] = '{16'hAAAA, 1'b0, 1'b1, 1'b1, T1_B1,  1'b1, 1'b0, 16'd1};
    tbl[8] = '{IDLE,     1'b1, 1'b1, 1'b0, 64'h0,  1'b0, 1'b0, 16'd1};

    // T1: basic frame from the table
    do_reset();
    for (int i = 0; i < 9; i++) begin
      cyc(tbl[i].d, tbl[i].k, tbl[i].rdy, "T1");
      chk("T1.valid", 66'(valid_out), 66'(tbl[i].e_valid));
      if (tbl[i].e_valid) begin
        chk("T1.data", 66'(data_out), 66'(tbl[i].e_data));
        chk("T1.last", 66'(last_out), 66'(tbl[i].e_last));
        chk("T1.err",  66'(err_out),  66'(tbl[i].e_err));
      end
      chk("T1.frm", 66'(frm_cnt), 66'(tbl[i].e_frm));
    end

    // T2: LEN=1, pad in lane 3 of the final beat
    do_reset();
    stim = '{SOF, SOF, 16'h0001, 16'h0001, 16'h5555, EOF, EOF};
    play(0, 1'b1, "T2");
    cyc(IDLE, 1'b1, 1'b1, "T2");
    chk("T2.nbeats", 66'(got.size()), 66'd2);
    if (got.size() == 2) begin
      chk("T2.beat0", got[0], {2'b00, 64'h0001_0001_A0AA_A0AA});
      chk("T2.beat1", got[1], {2'b10, 64'h0000_AAAA_AAAA_5555});
    end

    // T3: idles between every word give the same beats as T1
    do_reset();
    stim = '{SOF, SOF, 16'h0001, 16'h0002, 16'h1111, 16'h2222, EOF, EOF};
    play(2, 1'b1, "T3");
    cyc(IDLE, 1'b1, 1'b1, "T3");
    chk("T3.nbeats", 66'(got.size()), 66'd2);
    if (got.size() == 2) begin
      chk("T3.beat0", got[0], {2'b00, T1_B0});
      chk("T3.beat1", got[1], {2'b10, T1_B1});
    end
    chk("T3.frm", 66'(frm_cnt), 66'd1);

    // T4: corrupted EOF2 flags the last beat
    do_reset();
    stim = '{SOF, SOF, 16'h0001, 16'h0002, 16'h1111, 16'h2222, EOF, 16'hAAAB};
    play(0, 1'b1, "T4");
    chk("T4.last", {last_out, err_out}, 66'b11);
    chk("T4.errcnt", 66'(err_cnt), 66'd1);
    chk("T4.frmcnt", 66'(frm_cnt), 66'd1);

    // T5: LEN above MAX_LEN aborts, next frame is clean
    do_reset();
    stim = '{SOF, SOF, 16'h0001, 16'h2000};
    play(0, 1'b1, "T5");
    chk("T5.abort", 66'(abort_out), 66'd1);
    chk("T5.drop", 66'(drop_cnt), 66'd1);
    chk("T5.nobeat", 66'(got.size()), 66'd0);
    cyc(IDLE, 1'b1, 1'b1, "T5");
    chk("T5.pulse", 66'(abort_out), 66'd0);
    stim = '{SOF, SOF, 16'h0001, 16'h0002, 16'h1111, 16'h2222, EOF, EOF};
    play(0, 1'b1, "T5");
    chk("T5.nbeats", 66'(got.size()), 66'd2);
    chk("T5.frm", 66'(frm_cnt), 66'd1);

    // T6: no ready, second beat overflows; then reset mid-payload
    do_reset();
    stim = '{SOF, SOF, 16'h0001, 16'h0008, 16'h1001, 16'h1002, 16'h1003, 16'h1004,
             16'h1005, 16'h1006, 16'h1007, 16'h1008, EOF, EOF};
    held = '0;
    foreach (stim[i]) begin
      cyc(stim[i], 1'b0, 1'b0, "T6");
      if (i == 3) held = data_out;
      if (i == 7) begin
        chk("T6.abort", 66'(abort_out), 66'd1);
        chk("T6.drop", 66'(drop_cnt), 66'd1);
        chk("T6.held", {valid_out, 1'b0, data_out}, {2'b10, 64'h0008_0001_A0AA_A0AA});
      end
    end
    chk("T6.stable", {valid_out, 1'b0, data_out}, {2'b10, held});
    chk("T6.frm", 66'(frm_cnt), 66'd0);
    stim = '{SOF, SOF, 16'h0001, 16'h0008, 16'h1234, 16'h1235};
    play(0, 1'b0, "T6");
    do_reset();
    chk("T6.rst_out", {valid_out, last_out, data_out}, 66'd0);
    chk("T6.rst_st", {err_out, abort_out, frm_cnt, err_cnt, drop_cnt}, 66'd0);

    // Randomized frames with idles, garbage, bad EOFs, big LENs and ready stalls
    do_reset();
    for (int f = 0; f < 300; f++) begin
      rmode = ($urandom_range(0, 2) == 0);
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
        rr = rmode ? ($urandom_range(0, 3) != 0) : 1'b1;
        cyc(16'($urandom), 1'($urandom), rr, "rnd");
      end
      len = ($urandom_range(0, 19) == 0) ? int'($urandom_range(4097, 9000)) : int'($urandom_range(0, 12));
      stim = '{SOF, SOF, 16'($urandom), 16'(len)};
      for (int p = 0; p < len && p < 13; p++) stim.push_back(16'($urandom));
      stim.push_back(($urandom_range(0, 7) == 0) ? 16'($urandom) : EOF);
      stim.push_back(($urandom_range(0, 7) == 0) ? 16'($urandom) : EOF);
      foreach (stim[i]) begin
        while ($urandom_range(0, 3) == 0) begin
          rr = rmode ? ($urandom_range(0, 3) != 0) : 1'b1;
          cyc(IDLE, 1'b1, rr, "rnd");
        end
        rr = rmode ? ($urandom_range(0, 3) != 0) : 1'b1;
        cyc(stim[i], 1'b0, rr, "rnd");
      end
    end
    got.delete();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
